// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// synchronous flush, sticky overflow/underflow flags and selectable
// first-word-fall-through read mode.
// Optional build macro SYNC_FIFO_PARITY_EN adds even parity per entry and o_perr.
module sync_fifo_lvl #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_rd,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_wfull,
  output logic             o_rempty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [ASIZE:0]   o_count,
  output logic             o_overflow,
`ifdef SYNC_FIFO_PARITY_EN
  output logic             o_underflow,
  output logic             o_perr
`else
  output logic             o_underflow
`endif
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned MW    = DSIZE + 1;
`else
  localparam int unsigned MW    = DSIZE;
`endif

  logic [MW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             wfull_q, wfull_d;
  logic             rempty_q, rempty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok_c, rd_ok_c;
  logic             bypass_c;
  logic [MW-1:0]    wword_c;
  logic [MW-1:0]    mem_rd_c;
`ifdef SYNC_FIFO_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Entry written into memory: data, plus even parity bit when enabled
`ifdef SYNC_FIFO_PARITY_EN
  assign wword_c = {^i_wdata, i_wdata};
`else
  assign wword_c = i_wdata;
`endif

  // Acceptance qualified by registered flags; a flush swallows both requests
  assign wr_ok_c = i_wr & ~wfull_q  & ~i_clr;
  assign rd_ok_c = i_rd & ~rempty_q & ~i_clr;

  // Next-state for pointers, level, flags and read data
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    bypass_c = 1'b0;
    mem_rd_c = '0;
`ifdef SYNC_FIFO_PARITY_EN
    perr_d   = 1'b0;
`endif

    if (i_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (FWFT != 0) rdata_d = '0;
    end else begin
      if (wr_ok_c) wptr_d = wptr_q + PW'(1);
      if (rd_ok_c) rptr_d = rptr_q + PW'(1);
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (i_wr & wfull_q);
      unf_d = unf_q | (i_rd & rempty_q);

      if (FWFT == 0) begin
        // Registered read: capture the popped head on an accepted read
        mem_rd_c = mem_q[rptr_q[ASIZE-1:0]];
        if (rd_ok_c) rdata_d = mem_rd_c[DSIZE-1:0];
`ifdef SYNC_FIFO_PARITY_EN
        perr_d = rd_ok_c & (^mem_rd_c);
`endif
      end else begin
        // Fall-through: preload the next head; forward the incoming word
        // when it lands in the slot that becomes the head this edge
        bypass_c = wr_ok_c & (rptr_d[ASIZE-1:0] == wptr_q[ASIZE-1:0]);
        mem_rd_c = bypass_c ? wword_c : mem_q[rptr_d[ASIZE-1:0]];
        rdata_d  = (count_d == '0) ? '0 : mem_rd_c[DSIZE-1:0];
`ifdef SYNC_FIFO_PARITY_EN
        perr_d = (count_d != '0) & (^mem_rd_c);
`endif
      end
    end

    wfull_d  = (count_d == PW'(DEPTH));
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= PW'(AFULL_TH));
    aempty_d = (count_d <= PW'(AEMPTY_TH));
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef SYNC_FIFO_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge i_clk) begin
    if (wr_ok_c) mem_q[wptr_q[ASIZE-1:0]] <= wword_c;
  end

  assign o_rdata        = rdata_q;
  assign o_wfull        = wfull_q;
  assign o_rempty       = rempty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
`ifdef SYNC_FIFO_PARITY_EN
  // Fall-through mode flags the head word during its pop cycle
  assign o_perr = (FWFT == 0) ? perr_q : (perr_q & rd_ok_c);
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Randomized bench for sync_fifo_lvl: one registered-read and one
// fall-through instance share stimulus and are checked against a queue model.
module tb_sync_fifo_lvl;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFT   = 12;
  localparam int unsigned AET   = 2;

  logic             clk = 1'b0;
  logic             rst_n, clr, wr, rd;
  logic [DSIZE-1:0] wdata;

  logic [DSIZE-1:0] rdata  [2];
  logic             wfull  [2];
  logic             rempty [2];
  logic             afull  [2];
  logic             aempty [2];
  logic [ASIZE:0]   count  [2];
  logic             ovf    [2];
  logic             unf    [2];
`ifdef SYNC_FIFO_PARITY_EN
  logic             perr   [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DSIZE-1:0] mq[$];
  logic             m_ovf, m_unf;
  logic [DSIZE-1:0] m_rd0;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
    .o_rdata(rdata[0]), .o_wfull(wfull[0]), .o_rempty(rempty[0]), .o_almost_full(afull[0]),
    .o_almost_empty(aempty[0]), .o_count(count[0]), .o_overflow(ovf[0]),
`ifdef SYNC_FIFO_PARITY_EN
    .o_underflow(unf[0]), .o_perr(perr[0])
`else
    .o_underflow(unf[0])
`endif
  );

  sync_fifo_lvl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
    .o_rdata(rdata[1]), .o_wfull(wfull[1]), .o_rempty(rempty[1]), .o_almost_full(afull[1]),
    .o_almost_empty(aempty[1]), .o_count(count[1]), .o_overflow(ovf[1]),
`ifdef SYNC_FIFO_PARITY_EN
    .o_underflow(unf[1]), .o_perr(perr[1])
`else
    .o_underflow(unf[1])
`endif
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
  endtask

  // Reference behaviour of one clock edge, from the current inputs
  task automatic model_step();
    bit full, empty;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (wr && full)  m_ovf = 1'b1;
      if (rd && empty) m_unf = 1'b1;
      if (rd && !empty) m_rd0 = mq.pop_front();
      if (wr && !full)  mq.push_back(wdata);
    end
  endtask

  task automatic check_all();
    int n;
    logic [DSIZE-1:0] exp_rd;
    n = mq.size();
    for (int i = 0; i < 2; i++) begin
      exp_rd = (i == 0) ? m_rd0 : ((n != 0) ? mq[0] : '0);
      check($sformatf("d%0d_count", i),  32'(count[i]),  32'(n));
      check($sformatf("d%0d_wfull", i),  32'(wfull[i]),  32'(n == DEPTH));
      check($sformatf("d%0d_rempty", i), 32'(rempty[i]), 32'(n == 0));
      check($sformatf("d%0d_afull", i),  32'(afull[i]),  32'(n >= AFT));
      check($sformatf("d%0d_aempty", i), 32'(aempty[i]), 32'(n <= AET));
      check($sformatf("d%0d_ovf", i),    32'(ovf[i]),    32'(m_ovf));
      check($sformatf("d%0d_unf", i),    32'(unf[i]),    32'(m_unf));
      check($sformatf("d%0d_rdata", i),  32'(rdata[i]),  32'(exp_rd));
`ifdef SYNC_FIFO_PARITY_EN
      check($sformatf("d%0d_perr", i),   32'(perr[i]),   32'(0));
`endif
    end
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge
  task automatic cyc(input logic w, input logic [DSIZE-1:0] d, input logic r, input logic c);
    wr = w; wdata = d; rd = r; clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) cyc(1'b1, DSIZE'(i), 1'b0, 1'b0);
    check("fill_wfull", 32'(wfull[0]), 32'(1));
    check("fill_count", 32'(count[0]), 32'(16));

    // Write attempt while full
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf[0]), 32'(1));

    // Drain 16, then one extra read
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("drain_seq", 32'(rdata[0]), 32'(i));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(unf[0]), 32'(1));

    // Fill to 8, then 20 cycles of simultaneous write/read
    for (int i = 0; i < 8; i++) cyc(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DSIZE'($urandom), 1'b1, 1'b0);
    check("steady_count", 32'(count[0]), 32'(8));

    // Fall-through visibility of the first word
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
    check("fwft_head", 32'(rdata[1]), 32'h5C);
    check("fwft_nempty", 32'(rempty[1]), 32'(0));
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("fwft_empty", 32'(rempty[1]), 32'(1));

    // Fill to 5, flush with a concurrent write
    for (int i = 0; i < 5; i++) cyc(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b1);
    check("clr_count", 32'(count[0]), 32'(0));

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 55), DSIZE'($urandom), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 39) == 0));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) cyc(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b1, 8'h78, 1'b0, 1'b0);
    check("post_rst_head", 32'(rdata[1]), 32'h77);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_first", 32'(rdata[0]), 32'h77);
    cyc(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
